// File: rtl/nms_pkg.sv
// ---------------------------------------------------------------------------
// nms_pkg
// Shared definitions for the FAST-9 non-maximum-suppression scan sequencer:
// default frame geometry and widths, the NMS_AddrCal neighbour codes, the
// sequencer state encoding and the tie-break classification helper.
// No ports (package).
// ---------------------------------------------------------------------------
package nms_pkg;

    localparam int NMS_COLUMNS = 180;
    localparam int NMS_ROWS    = 120;
    localparam int NMS_ADDR_W  = 15;
    localparam int NMS_SCORE_W = 8;

    // NMS_AddrCal expects the centre address biased by one row plus one
    // column, so that every neighbour address stays non-negative.
    localparam int REF_OFFSET  = NMS_COLUMNS + 1;

    localparam logic [3:0] ADJ_CENTRE = 4'd0;
    localparam logic [3:0] ADJ_N      = 4'd1;
    localparam logic [3:0] ADJ_NE     = 4'd2;
    localparam logic [3:0] ADJ_E      = 4'd3;
    localparam logic [3:0] ADJ_SE     = 4'd4;
    localparam logic [3:0] ADJ_S      = 4'd5;
    localparam logic [3:0] ADJ_SW     = 4'd6;
    localparam logic [3:0] ADJ_W      = 4'd7;
    localparam logic [3:0] ADJ_NW     = 4'd8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } nms_state_t;

    // Neighbours that come later in raster order (E, SE, S, SW) must be
    // strictly beaten; earlier ones only need to be matched. Two equal
    // adjacent scores therefore keep exactly one of the pair.
    function automatic logic adj_is_strict(input logic [3:0] adj);
        return (adj == ADJ_E) || (adj == ADJ_SE) ||
               (adj == ADJ_S) || (adj == ADJ_SW);
    endfunction

endpackage

// File: rtl/nms_cmp.sv
// ---------------------------------------------------------------------------
// nms_cmp
// Combinational centre-versus-neighbour comparator carrying the NMS
// tie-break rule.
// Ports:
//   centre    in  SCORE_W  centre pixel score
//   neighbour in  SCORE_W  neighbour pixel score
//   adj       in  4        neighbour code (1..8 = N,NE,E,SE,S,SW,W,NW)
//   pass      out 1        centre survives this neighbour
// ---------------------------------------------------------------------------
module nms_cmp
    import nms_pkg::*;
#(
    parameter int SCORE_W = NMS_SCORE_W
) (
    input  logic [SCORE_W-1:0] centre,
    input  logic [SCORE_W-1:0] neighbour,
    input  logic [3:0]         adj,
    output logic               pass
);

    always_comb begin
        pass = 1'b0;
        if (adj_is_strict(adj)) begin
            pass = (centre > neighbour);
        end else begin
            pass = (centre >= neighbour);
        end
    end

endmodule

// File: rtl/nms_scan_ctrl.sv
// ---------------------------------------------------------------------------
// nms_scan_ctrl
// Sequencer for the FAST-9 non-maximum-suppression stage. Raster-scans every
// interior pixel of the score map, issues the nine score reads (centre then
// N,NE,E,SE,S,SW,W,NW) through NMS_AddrCal, compares the centre against its
// neighbours and emits surviving keypoints on a valid/ready stream.
//
// Optional feature (macro NMS_EARLY_EXIT_EN): when the centre score returns
// as zero, the in-flight neighbour read is dropped and the scan moves to the
// next centre, so a zero centre costs 3 cycles instead of 11.
//
// Ports:
//   clk            in  1        clock, rising edge
//   reset          in  1        synchronous, active-high
//   start          in  1        begin frame scan (ignored while busy)
//   ref_addr       out ADDR_W   centre address + OFFSET, to NMS_AddrCal
//   adj_number     out 4        neighbour code, 0 when not reading
//   score_rd_en    out 1        score memory read strobe
//   score_rd_data  in  SCORE_W  read data, valid 1 cycle after score_rd_en
//   kp_valid       out 1        keypoint available
//   kp_ready       in  1        downstream accepts keypoint
//   kp_addr        out ADDR_W   keypoint address, row*COLUMNS+col
//   kp_score       out SCORE_W  keypoint score
//   busy           out 1        scan in progress
//   done           out 1        one-cycle pulse at end of frame
// ---------------------------------------------------------------------------
module nms_scan_ctrl
    import nms_pkg::*;
#(
    parameter int COLUMNS = NMS_COLUMNS,
    parameter int ROWS    = NMS_ROWS,
    parameter int ADDR_W  = NMS_ADDR_W,
    parameter int SCORE_W = NMS_SCORE_W,
    parameter int OFFSET  = REF_OFFSET
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  ref_addr,
    output logic [3:0]         adj_number,
    output logic               score_rd_en,
    input  logic [SCORE_W-1:0] score_rd_data,
    output logic               kp_valid,
    input  logic               kp_ready,
    output logic [ADDR_W-1:0]  kp_addr,
    output logic [SCORE_W-1:0] kp_score,
    output logic               busy,
    output logic               done
);

    localparam int COL_W = $clog2(COLUMNS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 2);
    localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 2);

    // First centre is (row 1, col 1).
    localparam logic [ADDR_W-1:0] REF_START = ADDR_W'(COLUMNS + 1 + OFFSET);
    localparam logic [ADDR_W-1:0] REF_BIAS  = ADDR_W'(OFFSET);
    localparam logic [ADDR_W-1:0] REF_STEP  = ADDR_W'(1);
    // Row wrap steps past the right border, the left border and onto col 1.
    localparam logic [ADDR_W-1:0] REF_WRAP  = ADDR_W'(3);

    nms_state_t state;
    nms_state_t state_next;

    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [3:0]         k;
    logic [ADDR_W-1:0]  ref_q;

    logic               rd_valid;
    logic [3:0]         rd_k;
    logic [SCORE_W-1:0] centre;
    logic               keep;

    logic               data_phase;
    logic               centre_hit;
    logic               neigh_hit;
    logic               cmp_pass;
    logic               keep_now;
    logic               early_exit;

    nms_cmp #(
        .SCORE_W (SCORE_W)
    ) u_cmp (
        .centre    (centre),
        .neighbour (score_rd_data),
        .adj       (rd_k),
        .pass      (cmp_pass)
    );

    // Returning data is only meaningful while the current centre is still
    // being gathered; a read left in flight by an early exit lands in NEXT
    // and is ignored.
    assign data_phase = (state == ISSUE) || (state == WAIT);
    assign centre_hit = data_phase && rd_valid && (rd_k == ADJ_CENTRE);
    assign neigh_hit  = data_phase && rd_valid && (rd_k != ADJ_CENTRE);

    always_comb begin
        keep_now = keep;
        if (centre_hit) begin
            keep_now = 1'b1;
        end else if (neigh_hit) begin
            keep_now = keep && cmp_pass;
        end
    end

`ifdef NMS_EARLY_EXIT_EN
    assign early_exit = centre_hit && (score_rd_data == '0);
`else
    assign early_exit = 1'b0;
`endif

    assign ref_addr = ref_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        score_rd_en = 1'b0;
        adj_number  = 4'd0;
        kp_valid    = 1'b0;
        kp_addr     = '0;
        kp_score    = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                score_rd_en = 1'b1;
                adj_number  = k;
                if (early_exit) begin
                    state_next = NEXT;
                end else if (k == ADJ_NW) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // keep_now already folds in the last (NW) compare.
                if (keep_now && (centre != '0)) begin
                    state_next = EMIT;
                end else begin
                    state_next = NEXT;
                end
            end
            EMIT: begin
                kp_valid = 1'b1;
                kp_addr  = ref_q - REF_BIAS;
                kp_score = centre;
                if (kp_ready) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if ((col == COL_LAST) && (row == ROW_LAST)) begin
                    state_next = DONE;
                end else begin
                    state_next = ISSUE;
                end
            end
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row      <= '0;
            col      <= '0;
            k        <= '0;
            ref_q    <= '0;
            rd_valid <= 1'b0;
            rd_k     <= '0;
            centre   <= '0;
            keep     <= 1'b0;
        end else begin
            rd_valid <= score_rd_en;
            rd_k     <= adj_number;
            keep     <= keep_now;
            if (centre_hit) begin
                centre <= score_rd_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        row   <= ROW_FIRST;
                        col   <= COL_FIRST;
                        k     <= '0;
                        ref_q <= REF_START;
                    end
                end
                ISSUE: begin
                    k <= k + 4'd1;
                end
                NEXT: begin
                    k <= '0;
                    if (col == COL_LAST) begin
                        if (row != ROW_LAST) begin
                            col   <= COL_FIRST;
                            row   <= row + ROW_W'(1);
                            ref_q <= ref_q + REF_WRAP;
                        end
                    end else begin
                        col   <= col + COL_W'(1);
                        ref_q <= ref_q + REF_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nms_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nms_scan_ctrl
// Bench for nms_scan_ctrl. A reduced 20x12 instance scans small score maps
// served by a behavioural NMS_AddrCal + score memory; a reference NMS model
// fills a scoreboard of expected keypoints and frame length. A second,
// default-geometry instance checks the 180-column address sequence.
// Honours NMS_EARLY_EXIT_EN for the expected timing.
// ---------------------------------------------------------------------------
module tb_nms_scan_ctrl;

    localparam int COLS   = 20;
    localparam int ROWS   = 12;
    localparam int OFF    = COLS + 1;
    localparam int NPIX   = COLS * ROWS;
    localparam int LIMIT  = 20000;
`ifdef NMS_EARLY_EXIT_EN
    localparam int CYC_ZERO = 3;
`else
    localparam int CYC_ZERO = 11;
`endif

    typedef struct {
        int addr;
        int score;
    } kp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] ref_addr;
    logic [3:0]  adj_number;
    logic        score_rd_en;
    logic [7:0]  score_rd_data;
    logic        kp_valid;
    logic        kp_ready;
    logic [14:0] kp_addr;
    logic [7:0]  kp_score;
    logic        busy;
    logic        done;

    logic        f_start;
    logic [14:0] f_ref_addr;
    logic [3:0]  f_adj_number;
    logic        f_score_rd_en;
    logic [7:0]  f_score_rd_data;
    logic        f_kp_valid;
    logic        f_kp_ready;
    logic [14:0] f_kp_addr;
    logic [7:0]  f_kp_score;
    logic        f_busy;
    logic        f_done;

    logic [7:0]  mem [NPIX];
    kp_t         exp_q[$];
    kp_t         mon_e;
    int          exp_cycles;
    int          tests = 0;
    int          failed = 0;
    int          done_count = 0;
    int          bad_addr = 0;
    int          rd_a;

    always #5 clk = ~clk;

    nms_scan_ctrl #(
        .COLUMNS (COLS),
        .ROWS    (ROWS),
        .ADDR_W  (15),
        .SCORE_W (8),
        .OFFSET  (OFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ref_addr      (ref_addr),
        .adj_number    (adj_number),
        .score_rd_en   (score_rd_en),
        .score_rd_data (score_rd_data),
        .kp_valid      (kp_valid),
        .kp_ready      (kp_ready),
        .kp_addr       (kp_addr),
        .kp_score      (kp_score),
        .busy          (busy),
        .done          (done)
    );

    nms_scan_ctrl u_full (
        .clk           (clk),
        .reset         (reset),
        .start         (f_start),
        .ref_addr      (f_ref_addr),
        .adj_number    (f_adj_number),
        .score_rd_en   (f_score_rd_en),
        .score_rd_data (f_score_rd_data),
        .kp_valid      (f_kp_valid),
        .kp_ready      (f_kp_ready),
        .kp_addr       (f_kp_addr),
        .kp_score      (f_kp_score),
        .busy          (f_busy),
        .done          (f_done)
    );

    function automatic int drOf(input int n);
        case (n)
            1, 2, 8: return -1;
            4, 5, 6: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int dcOf(input int n);
        case (n)
            2, 3, 4: return 1;
            6, 7, 8: return -1;
            default: return 0;
        endcase
    endfunction

    // Behavioural NMS_AddrCal plus one-cycle-latency score memory.
    always @(posedge clk) begin
        if (score_rd_en) begin
            rd_a = int'(ref_addr) - OFF + COLS * drOf(int'(adj_number)) + dcOf(int'(adj_number));
            if (rd_a < 0 || rd_a >= NPIX) begin
                bad_addr++;
                score_rd_data <= 8'h00;
            end else begin
                score_rd_data <= mem[rd_a];
            end
        end else begin
            score_rd_data <= 8'hA5;
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_count++;
        if (kp_valid && kp_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("kp_unexpected_addr", int'(kp_addr), -1);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("kp_addr", int'(kp_addr), mon_e.addr);
                checkOutput("kp_score", int'(kp_score), mon_e.score);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMem();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
    endtask

    // Reference NMS: expected keypoints in raster order and frame length
    // with kp_ready held high.
    task automatic buildExpected();
        kp_t e;
        exp_q.delete();
        exp_cycles = 0;
        for (int r = 1; r <= ROWS - 2; r++) begin
            for (int c = 1; c <= COLS - 2; c++) begin
                int  ctr;
                int  nb;
                logic keep;
                ctr  = int'(mem[r * COLS + c]);
                keep = (ctr != 0);
                for (int n = 1; n <= 8; n++) begin
                    nb = int'(mem[(r + drOf(n)) * COLS + c + dcOf(n)]);
                    if (n >= 3 && n <= 6) keep = keep && (ctr > nb);
                    else                  keep = keep && (ctr >= nb);
                end
                exp_cycles += (ctr == 0) ? CYC_ZERO : 11;
                if (keep) begin
                    e.addr  = r * COLS + c;
                    e.score = ctr;
                    exp_q.push_back(e);
                    exp_cycles += 1;
                end
            end
        end
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic runFrame(input string name, input logic check_cycles);
        int cycles;
        int d0;
        buildExpected();
        d0 = done_count;
        applyStimulus();
        checkOutput({name, "_busy"}, int'(busy), 1);
        checkOutput({name, "_ref_start"}, int'(ref_addr), 2 * COLS + 2);
        cycles = 0;
        while (!done && cycles < LIMIT) begin
            step();
            cycles++;
        end
        checkOutput({name, "_done"}, int'(done), 1);
        if (check_cycles) checkOutput({name, "_cycles"}, cycles, exp_cycles);
        checkOutput({name, "_left"}, exp_q.size(), 0);
        step();
        checkOutput({name, "_done_width"}, int'(done), 0);
        checkOutput({name, "_idle"}, int'(busy), 0);
        checkOutput({name, "_pulses"}, done_count - d0, 1);
    endtask

    initial begin
        int   cycles;
        int   bad;
        int   d0;
        logic [14:0] hold_addr;
        logic [7:0]  hold_score;

        reset = 1'b1;
        start = 1'b0;
        kp_ready = 1'b1;
        f_start = 1'b0;
        f_kp_ready = 1'b1;
        f_score_rd_data = 8'd0;
        clearMem();
        repeat (3) step();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_kp_valid", int'(kp_valid), 0);
        checkOutput("rst_rd_en", int'(score_rd_en), 0);
        checkOutput("rst_ref_addr", int'(ref_addr), 0);
        checkOutput("rst_full_ref_addr", int'(f_ref_addr), 0);
        reset = 1'b0;
        step();

        // Default geometry: address sequence across the first row wrap.
        f_start = 1'b1;
        step();
        f_start = 1'b0;
        checkOutput("full_ref_start", int'(f_ref_addr), 362);
        checkOutput("full_rd_en", int'(f_score_rd_en), 1);
        checkOutput("full_adj0", int'(f_adj_number), 0);
        for (int i = 1; i <= CYC_ZERO * 178; i++) begin
            step();
`ifndef NMS_EARLY_EXIT_EN
            if (i <= 8) checkOutput("full_adj_walk", int'(f_adj_number), i);
            if (i == 9) checkOutput("full_wait_rd_en", int'(f_score_rd_en), 0);
`endif
            if (i == CYC_ZERO)       checkOutput("full_ref_col2", int'(f_ref_addr), 363);
            if (i == CYC_ZERO * 177) checkOutput("full_ref_col178", int'(f_ref_addr), 539);
            if (i == CYC_ZERO * 178) begin
                checkOutput("full_ref_wrap", int'(f_ref_addr), 542);
                checkOutput("full_wrap_adj", int'(f_adj_number), 0);
            end
        end

        clearMem();
        runFrame("zero", 1'b1);

        clearMem();
        mem[5 * COLS + 7] = 8'd50;
        runFrame("single", 1'b1);

        clearMem();
        mem[4 * COLS + 10] = 8'd30;
        mem[4 * COLS + 11] = 8'd30;
        runFrame("tie", 1'b1);

        clearMem();
        mem[0]        = 8'd99;
        mem[COLS - 1] = 8'd99;
        mem[COLS + 1] = 8'd40;
        runFrame("border", 1'b1);

        for (int i = 0; i < NPIX; i++) begin
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
        end
        runFrame("random", 1'b1);
        checkOutput("addr_range", bad_addr, 0);

        // Back-pressure on a single keypoint at (3,4).
        clearMem();
        mem[3 * COLS + 4] = 8'd77;
        buildExpected();
        kp_ready = 1'b0;
        applyStimulus();
        cycles = 0;
        while (!kp_valid && cycles < LIMIT) begin
            step();
            cycles++;
        end
        checkOutput("bp_valid_seen", int'(kp_valid), 1);
        checkOutput("bp_addr", int'(kp_addr), 3 * COLS + 4);
        checkOutput("bp_score", int'(kp_score), 77);
        hold_addr  = kp_addr;
        hold_score = kp_score;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (kp_valid !== 1'b1 || kp_addr !== hold_addr ||
                kp_score !== hold_score || score_rd_en !== 1'b0) bad++;
        end
        checkOutput("bp_hold", bad, 0);
        kp_ready = 1'b1;
        step();
        checkOutput("bp_release_valid", int'(kp_valid), 0);
        checkOutput("bp_release_rd", int'(score_rd_en), 0);
        step();
        checkOutput("bp_resume_rd", int'(score_rd_en), 1);
        checkOutput("bp_resume_adj", int'(adj_number), 0);
        checkOutput("bp_resume_ref", int'(ref_addr), 3 * COLS + 5 + OFF);
        cycles = 0;
        while (!done && cycles < LIMIT) begin
            step();
            cycles++;
        end
        checkOutput("bp_done", int'(done), 1);
        checkOutput("bp_left", exp_q.size(), 0);
        step();

        // Reset 500 cycles into a scan aborts it without a done pulse.
        clearMem();
        mem[5 * COLS + 7] = 8'd50;
        buildExpected();
        applyStimulus();
        d0 = done_count;
        repeat (500) step();
        checkOutput("abort_busy_before", int'(busy), 1);
        reset = 1'b1;
        step();
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_kp_valid", int'(kp_valid), 0);
        checkOutput("abort_kp_addr", int'(kp_addr), 0);
        checkOutput("abort_kp_score", int'(kp_score), 0);
        checkOutput("abort_rd_en", int'(score_rd_en), 0);
        checkOutput("abort_adj", int'(adj_number), 0);
        checkOutput("abort_ref_addr", int'(ref_addr), 0);
        checkOutput("abort_full_busy", int'(f_busy), 0);
        step();
        reset = 1'b0;
        exp_q.delete();
        step();
        checkOutput("abort_no_done", done_count - d0, 0);
        runFrame("rescan", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/nms_scan_ctrl.md
Name: nms_scan_ctrl

Overview:
- Sequencer for the FAST-9 non-maximum-suppression stage.
- Raster-scans every interior pixel of the 180x120 score map and drives `ref_addr`/`adj_number` into NMS_AddrCal; the resulting address feeds the score memory.
- Consumes the returned scores and compares the centre against its 8 neighbours.
- Emits surviving keypoints on a valid/ready stream to the keypoint output stage.

Parameters:
- COLUMNS, 180, image width in pixels
- ROWS, 120, image height in pixels
- ADDR_W, 15, score-memory address width
- SCORE_W, 8, score width (unsigned)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin frame scan; ignored while busy
- ref_addr  out  ADDR_W  centre address + 181, to NMS_AddrCal refAddr
- adj_number  out  4  0=centre, 1..8=N,NE,E,SE,S,SW,W,NW, to NMS_AddrCal
- score_rd_en  out  1  score memory read strobe
- score_rd_data  in  SCORE_W  score read data, valid 1 cycle after score_rd_en
- kp_valid  out  1  keypoint available
- kp_ready  in  1  downstream accepts keypoint
- kp_addr  out  ADDR_W  keypoint centre address, row*COLUMNS+col
- kp_score  out  SCORE_W  keypoint score
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state IDLE; all outputs 0; row/col/k counters 0. Reset mid-scan aborts the frame immediately; no done pulse.
- Scan range: rows 1..ROWS-2, cols 1..COLUMNS-2 (118x178 = 21004 centres). Border pixels are never centres but are read as neighbours.
- ref_addr maintenance: updated incrementally, no multiplier. Start value 1*COLUMNS+1+181 = 362. +1 per column step; +3 on row wrap (skips the two border columns).
- IDLE:
  - busy=0.
  - start=1: row=1, col=1, k=0; go to ISSUE.
- ISSUE:
  - score_rd_en=1, adj_number=k; k increments each cycle.
  - After k=8 is issued, go to WAIT.
- Read pipeline: a 1-cycle rd_valid/rd_k shadow tags the returning data.
  - Data for k=0 loads the centre register and sets keep=1.
  - Data for k=1..8 clears keep if the compare fails.
- Compare rule (tie-break, antisymmetric so exactly one of two equal neighbours survives):
  - Neighbours 1,2,7,8 (N, NE, W, NW): pass if centre >= n.
  - Neighbours 3,4,5,6 (E, SE, S, SW): pass if centre > n.
- WAIT: the last datum (k=8) is compared this cycle.
  - keep=1 and centre!=0: go to EMIT.
  - Otherwise: go to NEXT.
- EMIT:
  - kp_valid=1; kp_addr=ref_addr-181; kp_score=centre.
  - All three held stable until kp_ready=1; that cycle is the transfer. Then go to NEXT.
  - No reads are issued while in EMIT.
- NEXT:
  - col==COLUMNS-2 and row==ROWS-2: go to DONE.
  - col==COLUMNS-2 otherwise: col=1, row+1, then ISSUE.
  - Otherwise: col+1, then ISSUE.
  - k is reset to 0 in all cases.
- DONE: done=1 for one cycle, busy=0; go to IDLE.
- busy=1 in every state except IDLE and DONE.
- Timing: 11 cycles per non-keypoint centre; keypoints add at least 1 EMIT cycle.
- adj_number is 0 whenever score_rd_en=0.

Optional Feature:
- Macro: NMS_EARLY_EXIT_EN
- Defined: when centre data (k=0) returns as 0, the in-flight k=1 read is discarded and the FSM goes to NEXT the following cycle. A zero-score centre then costs 3 cycles.
- Undefined: all 9 reads are always issued; timing is fixed at 11 cycles per centre.

Decomposition:
- Package nms_pkg:
  - COLUMNS/ROWS defaults.
  - ADJ_CENTRE..ADJ_NW codes (0..8).
  - State enum: IDLE, ISSUE, WAIT, EMIT, NEXT, DONE.
  - Offset constant 181.
- Sub-module nms_cmp: combinational, inputs (centre, neighbour, adj code), output pass; encodes the tie-break rule.

Test Plan:
- All-zero score memory, start: no kp_valid; done pulses 231044 cycles after start (undefined macro) or 63012 cycles (NMS_EARLY_EXIT_EN).
- Single score 50 at addr 907 (row5, col7), rest 0: exactly one keypoint, kp_addr=907, kp_score=50.
- Equal scores 30 at addrs 1810 and 1811: only kp_addr=1811 emitted; 1810 fails the E (>) compare.
- Border: score 99 at addr 0 and addr 179, score 40 at addr 181: no keypoint from addr 0 or 179; 181 suppressed by its NW neighbour (99).
- Back-pressure: keypoint pending with kp_ready low for 20 cycles: kp_valid held at 1; kp_addr/kp_score stable; score_rd_en=0; scan resumes the cycle after kp_ready=1.
- Reset asserted 500 cycles into scan: next cycle all outputs 0, state IDLE, no done; a new start rescans from ref_addr=362.
